fifo_test_engine: RTL
=====================

FIFO_TEST_ENGINE -- requirements
Module: fifo_test_engine

Interface
REQ-001 SHALL have parameter PIO_BASE, default 16, giving the first of three consecutive PIO register addresses.
REQ-002 SHALL have parameter ERR_WIDTH, default 32, giving the error counter width.
REQ-003 SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pio_write_valid, input, 1, PIO write strobe.
REQ-006 SHALL have port pio_write_data, input, 64, PIO write data.
REQ-007 SHALL have port pio_address, input, 13, PIO write address.
REQ-008 SHALL have port tpc_data, output, 64, generated word to the to-PC FIFO.
REQ-009 SHALL have port tpc_write, output, 1, to-PC FIFO write strobe.
REQ-010 SHALL have port tpc_ready, input, 1, to-PC FIFO can accept one word next cycle.
REQ-011 SHALL have port fpc_data, input, 64, word from the from-PC FIFO.
REQ-012 SHALL have port fpc_read, output, 1, from-PC FIFO read enable.
REQ-013 SHALL have port fpc_valid, input, 1, fpc_data valid.
REQ-014 SHALL have port error_count, output, ERR_WIDTH, saturating checker mismatch count.
REQ-015 SHALL have port gen_done, output, 1, generator finished its programmed length.

Function
REQ-016 SHALL decode PIO writes: PIO_BASE+0 control (bit0 gen_en, bit1 chk_en, bit2 clear), PIO_BASE+1 gen_length (64-bit, 0 = unlimited), PIO_BASE+2 seed (64-bit, used by both generator and checker).
REQ-017 Generator SHALL implement states IDLE, RUN and DONE.
REQ-018 Generator SHALL move from IDLE to RUN on a control write with gen_en=1, loading sent=0 and next=seed.
REQ-019 In RUN, for each cycle N with tpc_ready=1, generator SHALL assert tpc_write=1 in cycle N+1 with tpc_data=next, then set next=next+1 (64-bit wrap, 0xFFFF_FFFF_FFFF_FFFF to 0) and sent=sent+1.
REQ-020 tpc_write SHALL be 0 in any cycle following tpc_ready=0.
REQ-021 When gen_length is nonzero and sent reaches gen_length, generator SHALL enter DONE, issue no further writes and assert gen_done=1.
REQ-022 A control write with gen_en=0 SHALL return the generator to IDLE from any state within one cycle.
REQ-023 A control write with gen_en=1 while in DONE SHALL restart the generator as in REQ-018.
REQ-024 fpc_read SHALL be registered and equal chk_en.
REQ-025 A word SHALL be accepted only in a cycle with fpc_read=1 and fpc_valid=1.
REQ-026 The checker SHALL compare each accepted word to expected, which is loaded with seed when chk_en rises.
REQ-027 On a match, expected SHALL become expected+1.
REQ-028 On a mismatch, error_count SHALL increment, saturating at all-ones, and expected SHALL become fpc_data+1 (resynchronise).
REQ-029 clear=1 SHALL zero error_count and gen_done and reload expected with seed; when clear and an enable arrive in the same write, clear SHALL apply first and the enable SHALL then take effect in that same write.
REQ-030 A mismatch in the same cycle as a clear write SHALL be discarded (count remains 0).
REQ-031 Writes to gen_length or seed during RUN SHALL take effect only at the next start.

Reset
REQ-032 On rst_n low, asynchronously: generator IDLE, tpc_write=0, tpc_data=0, fpc_read=0, error_count=0, gen_done=0, gen_en=chk_en=0, gen_length=0, seed=0, expected=0.
REQ-033 Reset asserted mid-transfer SHALL abort it with no further tpc_write; after release, the block SHALL stay idle until a new control write.

Structure
REQ-034 The register offsets (0, 1, 2), control bit positions and generator state encoding SHALL live in a shared package, fifo_test_pkg.
REQ-035 The checker SHALL be a sub-module, fifo_test_checker; the generator and PIO decode SHALL stay in the top module.

Verification
REQ-036 Write seed=0x10, gen_length=4, control=1 with tpc_ready held high -> exactly 4 writes with data 0x10, 0x11, 0x12, 0x13, then gen_done=1.
REQ-037 Toggle tpc_ready 1,0,1,1,0 during RUN -> tpc_write follows it one cycle later as 1,0,1,1,0, with data contiguous.
REQ-038 Set seed=0xFFFF_FFFF_FFFF_FFFE, gen_length=3 -> data FFFE, FFFF, 0 in the upper-ones pattern, then DONE.
REQ-039 Set chk_en=1, seed=5, feed 5, 6, 9, 10 -> error_count=1 and no error on 10.
REQ-040 Preload error_count to all-ones minus 1, then inject 3 mismatches -> error_count saturates at all-ones; a control write with clear=1 -> 0.
REQ-041 Pull rst_n low mid-RUN after 2 words -> tpc_write=0 immediately and all outputs take reset values; no writes occur after release until gen_en is written.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// Shared register map, control bit positions and generator state encoding
// for the FIFO test engine.
package fifo_test_pkg;

  localparam int REG_CONTROL = 0;
  localparam int REG_LENGTH  = 1;
  localparam int REG_SEED    = 2;

  localparam int CTRL_GEN_EN = 0;
  localparam int CTRL_CHK_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_RUN  = 2'd1,
    GEN_DONE = 2'd2
  } gen_state_t;

  function automatic logic [12:0] reg_addr(input int base, input int offset);
    return 13'(base + offset);
  endfunction

endpackage

// File: rtl/fifo_test_checker.sv
// Checks the incrementing word stream coming back from the PC and counts
// mismatches, resynchronising to the received word after each error.
module fifo_test_checker
  import fifo_test_pkg::*;
#(
  parameter int ERR_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 chk_en,
  input  logic                 clear,
  input  logic [63:0]          seed,
  input  logic [63:0]          fpc_data,
  input  logic                 fpc_valid,
  output logic                 fpc_read,
  output logic [ERR_WIDTH-1:0] error_count
);

  logic [63:0] expected;

  // fpc_read doubles as the delayed enable, so chk_en && !fpc_read marks the rise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fpc_read    <= 1'b0;
      expected    <= 64'd0;
      error_count <= '0;
    end else begin
      fpc_read <= chk_en;
      if (clear) begin
        error_count <= '0;
        expected    <= seed;
      end else if (chk_en && !fpc_read) begin
        expected <= seed;
      end else if (fpc_read && fpc_valid) begin
        if (fpc_data == expected) begin
          expected <= expected + 64'd1;
        end else begin
          if (error_count != '1) begin
            error_count <= error_count + ERR_WIDTH'(1);
          end
          expected <= fpc_data + 64'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_test_engine.sv
// FIFO loopback test engine: PIO register decode, an incrementing-word
// generator feeding the to-PC FIFO, and a checker on the from-PC FIFO.
module fifo_test_engine
  import fifo_test_pkg::*;
#(
  parameter int PIO_BASE  = 16,
  parameter int ERR_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 pio_write_valid,
  input  logic [63:0]          pio_write_data,
  input  logic [12:0]          pio_address,
  output logic [63:0]          tpc_data,
  output logic                 tpc_write,
  input  logic                 tpc_ready,
  input  logic [63:0]          fpc_data,
  output logic                 fpc_read,
  input  logic                 fpc_valid,
  output logic [ERR_WIDTH-1:0] error_count,
  output logic                 gen_done
);

  logic        ctrl_hit, length_hit, seed_hit;
  logic        start, stop, clear, load, issue, finish;
  logic        gen_en, chk_en;
  logic [63:0] gen_length, seed, run_length, sent, next_word;
  gen_state_t  state, state_next;

  assign ctrl_hit   = pio_write_valid && (pio_address == reg_addr(PIO_BASE, REG_CONTROL));
  assign length_hit = pio_write_valid && (pio_address == reg_addr(PIO_BASE, REG_LENGTH));
  assign seed_hit   = pio_write_valid && (pio_address == reg_addr(PIO_BASE, REG_SEED));

  assign start = ctrl_hit && pio_write_data[CTRL_GEN_EN];
  assign stop  = ctrl_hit && !pio_write_data[CTRL_GEN_EN];
  assign clear = ctrl_hit && pio_write_data[CTRL_CLEAR];
  // Starting from RUN is ignored so an enable rewrite does not rewind the stream.
  assign load  = start && (state != GEN_RUN);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gen_en     <= 1'b0;
      chk_en     <= 1'b0;
      gen_length <= 64'd0;
      seed       <= 64'd0;
    end else begin
      if (ctrl_hit) begin
        gen_en <= pio_write_data[CTRL_GEN_EN];
        chk_en <= pio_write_data[CTRL_CHK_EN];
      end
      if (length_hit) gen_length <= pio_write_data;
      if (seed_hit)   seed       <= pio_write_data;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      GEN_RUN: begin
        if (stop || !gen_en) begin
          state_next = GEN_IDLE;
        end else if (tpc_ready) begin
          issue = 1'b1;
          if ((run_length != 64'd0) && (sent + 64'd1 == run_length)) begin
            state_next = GEN_DONE;
            finish     = 1'b1;
          end
        end
      end
      default: begin
        if (start)     state_next = GEN_RUN;
        else if (stop) state_next = GEN_IDLE;
      end
    endcase
  end

  // Length and seed are sampled only at start, so rewrites during RUN wait for the next run.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GEN_IDLE;
      tpc_write  <= 1'b0;
      tpc_data   <= 64'd0;
      next_word  <= 64'd0;
      sent       <= 64'd0;
      run_length <= 64'd0;
      gen_done   <= 1'b0;
    end else begin
      state     <= state_next;
      tpc_write <= issue;
      if (issue) begin
        tpc_data  <= next_word;
        next_word <= next_word + 64'd1;
        sent      <= sent + 64'd1;
      end
      if (load) begin
        next_word  <= seed;
        sent       <= 64'd0;
        run_length <= gen_length;
      end
      if (clear || load) gen_done <= 1'b0;
      else if (finish)   gen_done <= 1'b1;
    end
  end

  fifo_test_checker #(
    .ERR_WIDTH(ERR_WIDTH)
  ) u_checker (
    .clock      (clock),
    .rst_n      (rst_n),
    .chk_en     (chk_en),
    .clear      (clear),
    .seed       (seed),
    .fpc_data   (fpc_data),
    .fpc_valid  (fpc_valid),
    .fpc_read   (fpc_read),
    .error_count(error_count)
  );

endmodule
